// File: rtl/cache_pkg.sv
// Cache front-end types: LL/SC sequencer states and counter width.
package cache_pkg;

  localparam int LLSC_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SC_WR   = 2'd1,
    SC_RESP = 2'd2
  } llsc_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by datapath and cache front end.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/llsc_ctrl_if.sv
// Bundle of the LL/SC sequencer's three sides: datapath, dcache and link register.
interface llsc_ctrl_if;
  import cpu_types_pkg::*;

  logic  dmemREN, dmemWEN, datomic, dhit;
  word_t dmemaddr, dmemstore, dmemload;
  logic  c_ren, c_wen, c_hit;
  word_t c_addr, c_store, c_load;
  logic  snoop_inv;
  word_t snoop_addr;
  logic  lm_update, lm_invalid_cpu, lm_invalid_bus, lm_write_valid;
  word_t lm_addr_cpu, lm_addr_bus;

  modport dp (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport dc (
    input  c_ren, c_wen, c_addr, c_store,
    output c_hit, c_load, snoop_inv, snoop_addr
  );

  modport lm (
    input  lm_update, lm_invalid_cpu, lm_invalid_bus, lm_addr_cpu, lm_addr_bus,
    output lm_write_valid
  );

  modport ctrl (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, c_hit, c_load,
           snoop_inv, snoop_addr, lm_write_valid,
    output dhit, dmemload, c_ren, c_wen, c_addr, c_store,
           lm_update, lm_invalid_cpu, lm_invalid_bus, lm_addr_cpu, lm_addr_bus
  );

endinterface

// File: rtl/llsc_stats.sv
// Saturating SC pass/fail event counters.
module llsc_stats
  import cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  pass_evt,
  input  logic                  fail_evt,
  output logic [LLSC_CNT_W-1:0] pass_cnt,
  output logic [LLSC_CNT_W-1:0] fail_cnt
);

  localparam logic [LLSC_CNT_W-1:0] CNT_MAX = '1;

  // Each counter sticks at all-ones once reached.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (pass_evt && pass_cnt != CNT_MAX)
        pass_cnt <= pass_cnt + 1'b1;
      if (fail_evt && fail_cnt != CNT_MAX)
        fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/llsc_ctrl.sv
// LL/SC sequencer between datapath memory port and dcache; drives the external link register.
// Optional LLSC_STATS_EN adds sc_pass_cnt/sc_fail_cnt saturating counters.
module llsc_ctrl
  import cpu_types_pkg::*;
  import cache_pkg::*;
(
`ifdef LLSC_STATS_EN
  output logic [LLSC_CNT_W-1:0] sc_pass_cnt,
  output logic [LLSC_CNT_W-1:0] sc_fail_cnt,
`endif
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  logic  datomic,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  dhit,
  output word_t dmemload,
  output logic  c_ren,
  output logic  c_wen,
  output word_t c_addr,
  output word_t c_store,
  input  logic  c_hit,
  input  word_t c_load,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  lm_update,
  output logic  lm_invalid_cpu,
  output logic  lm_invalid_bus,
  output word_t lm_addr_cpu,
  output word_t lm_addr_bus,
  input  logic  lm_write_valid
);

  llsc_state_t state;
  logic        result;
  logic        snoop_match;

  assign snoop_match    = snoop_inv && (snoop_addr == dmemaddr);
  assign lm_invalid_bus = snoop_inv;
  assign lm_addr_bus    = snoop_addr;
  assign lm_addr_cpu    = dmemaddr;

  // A cache hit in SC_WR wins over a same-cycle snoop: the write already landed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      result <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmemWEN && datomic) begin
            if (lm_write_valid) begin
              state <= SC_WR;
            end else begin
              result <= 1'b0;
              state  <= SC_RESP;
            end
          end
        end
        SC_WR: begin
          if (c_hit) begin
            result <= 1'b1;
            state  <= SC_RESP;
          end else if (snoop_match) begin
            result <= 1'b0;
            state  <= SC_RESP;
          end
        end
        SC_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dhit           = 1'b0;
    dmemload       = '0;
    c_ren          = 1'b0;
    c_wen          = 1'b0;
    c_addr         = dmemaddr;
    c_store        = dmemstore;
    lm_update      = 1'b0;
    lm_invalid_cpu = 1'b0;
    case (state)
      IDLE: begin
        if (dmemREN) begin
          c_ren     = 1'b1;
          dhit      = c_hit;
          dmemload  = c_load;
          lm_update = datomic && c_hit;
        end else if (dmemWEN && !datomic) begin
          c_wen          = 1'b1;
          dhit           = c_hit;
          lm_invalid_cpu = c_hit;
        end
      end
      SC_WR: begin
        c_wen          = 1'b1;
        lm_invalid_cpu = c_hit;
      end
      SC_RESP: begin
        dhit     = 1'b1;
        dmemload = {{(WORD_W-1){1'b0}}, result};
      end
      default: ;
    endcase
  end

`ifdef LLSC_STATS_EN
  llsc_stats u_stats (
    .CLK      (CLK),
    .nRST     (nRST),
    .pass_evt (state == SC_RESP && result),
    .fail_evt (state == SC_RESP && !result),
    .pass_cnt (sc_pass_cnt),
    .fail_cnt (sc_fail_cnt)
  );
`endif

endmodule

// File: tb/tb_llsc_ctrl.sv
// Directed self-checking bench for llsc_ctrl; stats checks compile in with LLSC_STATS_EN.
module tb_llsc_ctrl;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  dmemREN, dmemWEN, datomic;
  word_t dmemaddr, dmemstore, dmemload;
  logic  dhit, c_ren, c_wen, c_hit;
  word_t c_addr, c_store, c_load;
  logic  snoop_inv;
  word_t snoop_addr;
  logic  lm_update, lm_invalid_cpu, lm_invalid_bus, lm_write_valid;
  word_t lm_addr_cpu, lm_addr_bus;
`ifdef LLSC_STATS_EN
  logic [15:0] sc_pass_cnt, sc_fail_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  llsc_ctrl dut (
`ifdef LLSC_STATS_EN
    .sc_pass_cnt    (sc_pass_cnt),
    .sc_fail_cnt    (sc_fail_cnt),
`endif
    .CLK            (CLK),
    .nRST           (nRST),
    .dmemREN        (dmemREN),
    .dmemWEN        (dmemWEN),
    .datomic        (datomic),
    .dmemaddr       (dmemaddr),
    .dmemstore      (dmemstore),
    .dhit           (dhit),
    .dmemload       (dmemload),
    .c_ren          (c_ren),
    .c_wen          (c_wen),
    .c_addr         (c_addr),
    .c_store        (c_store),
    .c_hit          (c_hit),
    .c_load         (c_load),
    .snoop_inv      (snoop_inv),
    .snoop_addr     (snoop_addr),
    .lm_update      (lm_update),
    .lm_invalid_cpu (lm_invalid_cpu),
    .lm_invalid_bus (lm_invalid_bus),
    .lm_addr_cpu    (lm_addr_cpu),
    .lm_addr_bus    (lm_addr_bus),
    .lm_write_valid (lm_write_valid)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ren, input logic wen, input logic atomic,
                               input word_t addr, input word_t store);
    dmemREN   = ren;
    dmemWEN   = wen;
    datomic   = atomic;
    dmemaddr  = addr;
    dmemstore = store;
  endtask

  // Advance to 1ns after the next rising edge; inputs change and outputs are checked there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    c_hit = 1'b0; c_load = '0; snoop_inv = 1'b0; snoop_addr = '0; lm_write_valid = 1'b0;
    tick(); tick();
    #1;
    checkOutput("rst_dhit", {31'b0, dhit}, 32'd0);
    checkOutput("rst_cren", {31'b0, c_ren}, 32'd0);
    checkOutput("rst_cwen", {31'b0, c_wen}, 32'd0);
    checkOutput("rst_load", dmemload, 32'd0);
    checkOutput("rst_upd", {31'b0, lm_update}, 32'd0);
`ifdef LLSC_STATS_EN
    checkOutput("rst_pass", {16'b0, sc_pass_cnt}, 32'd0);
    checkOutput("rst_fail", {16'b0, sc_fail_cnt}, 32'd0);
`endif
    nRST = 1'b1;

    // LL 0x100, hit on the fourth cycle
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, '0);
    c_load = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("ll_cren", {31'b0, c_ren}, 32'd1);
      checkOutput("ll_wait_dhit", {31'b0, dhit}, 32'd0);
      checkOutput("ll_wait_upd", {31'b0, lm_update}, 32'd0);
      tick();
    end
    c_hit = 1'b1;
    #1;
    checkOutput("ll_dhit", {31'b0, dhit}, 32'd1);
    checkOutput("ll_load", dmemload, 32'hDEADBEEF);
    checkOutput("ll_upd", {31'b0, lm_update}, 32'd1);
    checkOutput("ll_lmaddr", lm_addr_cpu, 32'h100);
    checkOutput("ll_caddr", c_addr, 32'h100);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    c_hit = 1'b0;
    #1;
    checkOutput("ll_upd_off", {31'b0, lm_update}, 32'd0);
    checkOutput("ll_dhit_off", {31'b0, dhit}, 32'd0);

    // SC 0x100 data 5 with a valid link: success
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h5);
    lm_write_valid = 1'b1;
    #1;
    checkOutput("sc_idle_cwen", {31'b0, c_wen}, 32'd0);
    checkOutput("sc_idle_dhit", {31'b0, dhit}, 32'd0);
    tick();
    lm_write_valid = 1'b0;
    #1;
    checkOutput("sc_wr_cwen", {31'b0, c_wen}, 32'd1);
    checkOutput("sc_wr_store", c_store, 32'h5);
    checkOutput("sc_wr_addr", c_addr, 32'h100);
    checkOutput("sc_wr_dhit", {31'b0, dhit}, 32'd0);
    tick();
    c_hit = 1'b1;
    #1;
    checkOutput("sc_hit_inv", {31'b0, lm_invalid_cpu}, 32'd1);
    checkOutput("sc_hit_dhit", {31'b0, dhit}, 32'd0);
    tick();
    c_hit = 1'b0;
    #1;
    checkOutput("sc_resp_dhit", {31'b0, dhit}, 32'd1);
    checkOutput("sc_resp_load", dmemload, 32'd1);
    checkOutput("sc_resp_cwen", {31'b0, c_wen}, 32'd0);
    checkOutput("sc_resp_inv", {31'b0, lm_invalid_cpu}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("sc_after_dhit", {31'b0, dhit}, 32'd0);

    // SC 0x200 without a link: fails without touching the cache
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'h9);
    #1;
    checkOutput("scf_c1_cwen", {31'b0, c_wen}, 32'd0);
    checkOutput("scf_c1_dhit", {31'b0, dhit}, 32'd0);
    tick();
    #1;
    checkOutput("scf_c2_dhit", {31'b0, dhit}, 32'd1);
    checkOutput("scf_c2_load", dmemload, 32'd0);
    checkOutput("scf_c2_cwen", {31'b0, c_wen}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // SC aborted by a matching snoop before c_hit
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h5);
    lm_write_valid = 1'b1;
    tick();
    lm_write_valid = 1'b0;
    snoop_inv = 1'b1; snoop_addr = 32'h100;
    #1;
    checkOutput("sca_wr_cwen", {31'b0, c_wen}, 32'd1);
    checkOutput("sca_bus_inv", {31'b0, lm_invalid_bus}, 32'd1);
    tick();
    snoop_inv = 1'b0; snoop_addr = '0;
    #1;
    checkOutput("sca_cwen_drop", {31'b0, c_wen}, 32'd0);
    checkOutput("sca_dhit", {31'b0, dhit}, 32'd1);
    checkOutput("sca_load", dmemload, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // SC survives an unrelated snoop; then c_hit beats a matching snoop
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h5);
    lm_write_valid = 1'b1;
    tick();
    lm_write_valid = 1'b0;
    snoop_inv = 1'b1; snoop_addr = 32'h104;
    tick();
    snoop_addr = 32'h100;
    c_hit = 1'b1;
    #1;
    checkOutput("scp_still_cwen", {31'b0, c_wen}, 32'd1);
    tick();
    snoop_inv = 1'b0; snoop_addr = '0; c_hit = 1'b0;
    #1;
    checkOutput("scp_dhit", {31'b0, dhit}, 32'd1);
    checkOutput("scp_load", dmemload, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Plain SW 0x100: link invalidate only in the hit cycle
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h77);
    #1;
    checkOutput("sw_cwen", {31'b0, c_wen}, 32'd1);
    checkOutput("sw_wait_inv", {31'b0, lm_invalid_cpu}, 32'd0);
    checkOutput("sw_wait_dhit", {31'b0, dhit}, 32'd0);
    tick();
    c_hit = 1'b1;
    #1;
    checkOutput("sw_inv", {31'b0, lm_invalid_cpu}, 32'd1);
    checkOutput("sw_dhit", {31'b0, dhit}, 32'd1);
    checkOutput("sw_store", c_store, 32'h77);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    c_hit = 1'b0;

    // Plain LW never updates the link
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h240, '0);
    c_hit = 1'b1; c_load = 32'h12345678;
    #1;
    checkOutput("lw_load", dmemload, 32'h12345678);
    checkOutput("lw_upd", {31'b0, lm_update}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    c_hit = 1'b0;

    // Idle snoop to 0x300
    snoop_inv = 1'b1; snoop_addr = 32'h300;
    #1;
    checkOutput("snp_inv", {31'b0, lm_invalid_bus}, 32'd1);
    checkOutput("snp_addr", lm_addr_bus, 32'h300);
    tick();
    snoop_inv = 1'b0; snoop_addr = '0;
    #1;
    checkOutput("snp_inv_off", {31'b0, lm_invalid_bus}, 32'd0);

`ifdef LLSC_STATS_EN
    // Two passes and two fails so far; one more fail makes three
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h208, 32'h1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("st_pass", {16'b0, sc_pass_cnt}, 32'd2);
    checkOutput("st_fail", {16'b0, sc_fail_cnt}, 32'd3);
`endif

    // Reset during SC_WR: immediate return to IDLE, no dhit
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h5);
    lm_write_valid = 1'b1;
    tick();
    lm_write_valid = 1'b0;
    #1;
    checkOutput("rsc_cwen_pre", {31'b0, c_wen}, 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("rsc_cwen", {31'b0, c_wen}, 32'd0);
    checkOutput("rsc_dhit", {31'b0, dhit}, 32'd0);
`ifdef LLSC_STATS_EN
    checkOutput("rsc_pass", {16'b0, sc_pass_cnt}, 32'd0);
    checkOutput("rsc_fail", {16'b0, sc_fail_cnt}, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    nRST = 1'b1;
    tick();
    #1;
    checkOutput("rsc_idle_dhit", {31'b0, dhit}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/llsc_ctrl.md
# llsc_ctrl

Load-linked/store-conditional sequencer in each core's data-cache front end, between the datapath memory port and the dcache controller. Passes ordinary loads/stores through, drives the per-core link register (update, CPU-side and bus-side invalidate), and runs SC as a short state machine that writes only while the link is valid. Returns the SC result (1 = success, 0 = fail) on the load-data path.

## Interface
Parameters:
- none (widths come from `word_t` in `cpu_types_pkg`)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- datomic  in  1  request is LL (with REN) or SC (with WEN)
- dmemaddr  in  32  datapath address
- dmemstore  in  32  datapath store data
- dhit  out  1  request complete this cycle
- dmemload  out  32  load data, or SC result zero-extended
- c_ren  out  1  read request to dcache
- c_wen  out  1  write request to dcache
- c_addr  out  32  address to dcache
- c_store  out  32  store data to dcache
- c_hit  in  1  dcache completed the current request
- c_load  in  32  dcache read data
- snoop_inv  in  1  coherence invalidation from bus this cycle
- snoop_addr  in  32  invalidated address
- lm_update  out  1  set link to lm_addr_cpu
- lm_invalid_cpu  out  1  local store clears matching link
- lm_invalid_bus  out  1  bus invalidation clears matching link
- lm_addr_cpu  out  32  equals dmemaddr
- lm_addr_bus  out  32  equals snoop_addr
- lm_write_valid  in  1  link valid and matches lm_addr_cpu (combinational)

## Operation
- States: IDLE, SC_WR, SC_RESP (`llsc_state_t`). Reset: IDLE, result register 0, all outputs 0.
- lm_invalid_bus = snoop_inv and lm_addr_bus = snoop_addr, combinational in every state.
- IDLE, plain LW (REN, !datomic): c_ren = 1, c_addr = dmemaddr, dhit = c_hit, dmemload = c_load.
- IDLE, plain SW (WEN, !datomic): c_wen = 1, c_store = dmemstore; dhit = c_hit; lm_invalid_cpu = c_hit.
- IDLE, LL: as LW; additionally lm_update = c_hit.
- IDLE, SC: no cache access this cycle. lm_write_valid = 0 → result = 0, go to SC_RESP. lm_write_valid = 1 → go to SC_WR.
- SC_WR: c_wen = 1, c_addr/c_store from datapath.
  - If c_hit: lm_invalid_cpu = 1, result = 1, go to SC_RESP.
  - Else if snoop_inv and snoop_addr == dmemaddr: drop c_wen next cycle, result = 0, go to SC_RESP.
  - c_hit takes priority over a same-cycle snoop.
- SC_RESP: dhit = 1, dmemload = {31'b0, result}, no cache request. Go to IDLE.
- REN and WEN both high is illegal. Behaviour is undefined; the bench must not drive it.

## Timing
- LW/SW/LL: combinational pass-through. dhit occurs in the same cycle as c_hit.
- SC fail from IDLE: dhit 1 cycle after the request is presented.
- SC success: dhit 1 cycle after c_hit.
- The datapath holds its request until dhit and changes or drops it in the cycle after dhit.
- LL hit and matching snoop in the same cycle: the link ends invalid, because the link register gives bus invalidation priority. The LL still returns data.
- Reset asserted mid-SC: return to IDLE immediately, c_wen drops, no dhit.

## Configuration
- LLSC_STATS_EN defined: adds outputs sc_pass_cnt and sc_fail_cnt, 16 bits each.
  - Each increments on leaving SC_RESP with the corresponding result.
  - Saturates at 16'hFFFF. Reset value 0.
- LLSC_STATS_EN undefined: these ports and counters do not exist. Functional behaviour is identical.

## Structure
- `llsc_state_t` (IDLE, SC_WR, SC_RESP) goes in `cache_pkg`.
- `word_t` comes from `cpu_types_pkg`.
- Add an interface `llsc_ctrl_if.vh` with modports for the datapath, dcache and link-module sides.
- The link register stays a separate instance, wired by the parent.
- One sub-module, `llsc_stats`: the saturating counter pair, instantiated only under LLSC_STATS_EN.

## Test plan
- LL 0x100 (c_load 0xDEADBEEF, c_hit after 3 cycles) → dmemload 0xDEADBEEF, lm_update pulses 1 cycle with lm_addr_cpu 0x100.
- LL 0x100, then SC 0x100 data 0x5 with lm_write_valid = 1 → c_wen asserted in SC_WR; after c_hit, dhit with dmemload 1; lm_invalid_cpu pulses.
- SC 0x200 with lm_write_valid = 0 → c_wen never asserted, dhit on cycle 2, dmemload 0.
- SC 0x100 in SC_WR, snoop_inv with snoop_addr 0x100 before c_hit → c_wen drops, dmemload 0. Same snoop in the cycle of c_hit → result 1.
- Plain SW 0x100 → lm_invalid_cpu high exactly in the c_hit cycle. Snoop to 0x300 → lm_invalid_bus high, lm_addr_bus 0x300.
- With LLSC_STATS_EN: 2 passes and 3 fails → sc_pass_cnt 2, sc_fail_cnt 3. nRST low during SC_WR → state IDLE, counters 0.
